pulse_train_gen: RTL and testbench
==================================

// Module: pulse_train_gen
// PURPOSE
//  Transmit side of the pulse-detection path: emits a programmed train of
//  COUNT high pulses, each WIDTH cycles long, separated by GAP low cycles.
//  Generates stimulus and control strobes for edge/pulse-detecting logic.
//  Requests are taken through a valid/ready handshake; completion is flagged
//  by a one-cycle done strobe.
// PARAMETERS
//  W_WIDTH  4  bits of req_width / req_gap fields (max phase = 2**W_WIDTH-1)
//  C_WIDTH  4  bits of req_count field (max pulses = 2**C_WIDTH-1)
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        reset, asynchronous, active-low
//  req_valid  in   1        request present
//  req_ready  out  1        block can accept a request
//  req_width  in   W_WIDTH  high-phase length in cycles
//  req_gap    in   W_WIDTH  low-phase length in cycles between pulses
//  req_count  in   C_WIDTH  number of pulses
//  abort      in   1        synchronous cancel of the running train
//  pulse      out  1        generated pulse train (registered)
//  busy       out  1        train in progress (state != IDLE)
//  done       out  1        one-cycle strobe: train completed normally
// BEHAVIOUR
//  Reset (rst=0): state IDLE; pulse=0, busy=0, done=0; req_ready=1 after release.
//  Accept: req_valid & req_ready at a rising edge; fields latched on that edge.
//  req_ready = (state==IDLE) & ~abort   (combinational).
//  FSM states: IDLE, HIGH, GAP.
//   IDLE -> HIGH on accept with width!=0 and count!=0. Pulse rises in the first
//     cycle after the accept (latency 1).
//   IDLE, accept with width==0 or count==0: no pulse; done=1 for the next cycle;
//     state stays IDLE.
//   HIGH: pulse=1 for exactly width cycles. Then either the last pulse ends ->
//     IDLE with done=1 in the first IDLE cycle, or -> GAP.
//   GAP: pulse=0 for gap cycles, then -> HIGH. gap==0 is treated as 1, so that
//     consecutive pulses stay separable by an edge detector.
//   No trailing gap after the last pulse.
//   done and req_ready are both 1 in the first IDLE cycle. A new request may be
//     accepted on that edge, so back-to-back trains are separated by >=1 low cycle.
//  Registers:
//   - phase down-counter: W_WIDTH bits, loaded with width or max(gap,1).
//   - pulse down-counter: C_WIDTH bits, decremented at the end of each HIGH.
//   - No arithmetic wrap: counters only load or decrement toward 0.
//  abort=1 in HIGH/GAP: next edge -> IDLE, pulse=0, counters cleared, done NOT
//    asserted. abort in IDLE: no effect, except that it blocks accept that cycle.
//  req_valid while busy: ignored, because req_ready=0. Input fields are don't-care
//    except at accept.
//  rst asserted mid-train: immediate IDLE, pulse=0, no done.
//  pulse, busy and done are all flop outputs (no combinational path from inputs).
// STRUCTURE
//  Package pulse_train_pkg:
//   - typedef enum logic [1:0] {IDLE, HIGH, GAP} ptg_state_t
//   - default W_WIDTH/C_WIDTH localparams
//  No sub-module: a single FSM plus two down-counters and the latched config.
// TESTING
//  1. width=2 gap=1 count=3 accepted at edge T
//     -> pulse 11011011 over cycles T+1..T+8; done=1 only at T+9; busy=1 T+1..T+8.
//  2. width=1 gap=0 count=2 -> pulse 101 (gap forced to 1); done one cycle after.
//  3. count=0 (or width=0) -> pulse stays 0; done=1 exactly one cycle after accept.
//  4. abort during the 2nd GAP of case 1 -> pulse 0 from next cycle; done never 1;
//     req_ready=1 next cycle.
//  5. req_valid held high with new fields through case 1 -> only the first request
//     runs; the second is accepted on the done cycle; one low cycle between trains.
//  6. rst pulled low mid-HIGH (async, between edges) -> pulse/busy drop immediately;
//     after release a fresh request runs cleanly.

Source files
------------

// File: rtl/pulse_train_gen_pkg.sv
// Shared types and default field widths for the pulse train generator.
package pulse_train_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } ptg_state_t;

    localparam int PTG_W_WIDTH = 4;
    localparam int PTG_C_WIDTH = 4;

endpackage

// File: rtl/pulse_train_gen_if.sv
// Request handshake, abort and train status signals of the pulse train generator.
interface pulse_train_gen_if #(
    parameter int W_WIDTH = pulse_train_pkg::PTG_W_WIDTH,
    parameter int C_WIDTH = pulse_train_pkg::PTG_C_WIDTH
);
    logic               req_valid;
    logic               req_ready;
    logic [W_WIDTH-1:0] req_width;
    logic [W_WIDTH-1:0] req_gap;
    logic [C_WIDTH-1:0] req_count;
    logic               abort;
    logic               pulse;
    logic               busy;
    logic               done;

    modport master (
        output req_valid, req_width, req_gap, req_count, abort,
        input  req_ready, pulse, busy, done
    );

    modport slave (
        input  req_valid, req_width, req_gap, req_count, abort,
        output req_ready, pulse, busy, done
    );
endinterface

// File: rtl/pulse_train_gen.sv
// Emits COUNT pulses of WIDTH high cycles separated by GAP low cycles, with a
// one-cycle done strobe on normal completion.
//
//  state | meaning
//  IDLE  | waiting for a request; req_ready high unless abort
//  HIGH  | pulse high, phase counter counting the width
//  GAP   | pulse low between pulses, phase counter counting max(gap,1)
module pulse_train_gen
    import pulse_train_pkg::*;
#(
    parameter int W_WIDTH = PTG_W_WIDTH,
    parameter int C_WIDTH = PTG_C_WIDTH
) (
    input logic clk,
    input logic rst,
    pulse_train_gen_if.slave bus
);

    localparam logic [W_WIDTH-1:0] PH_ONE  = W_WIDTH'(1);
    localparam logic [C_WIDTH-1:0] CNT_ONE = C_WIDTH'(1);

    ptg_state_t         state_q, state_d;
    logic [W_WIDTH-1:0] phase_q, phase_d;
    logic [C_WIDTH-1:0] cnt_q, cnt_d;
    logic [W_WIDTH-1:0] width_q, width_d;
    logic [W_WIDTH-1:0] gap_q, gap_d;
    logic               pulse_q, pulse_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               accept;

    assign bus.req_ready = (state_q == IDLE) && !bus.abort;
    assign accept        = bus.req_valid && bus.req_ready;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        width_d = width_q;
        gap_d   = gap_q;
        pulse_d = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    width_d = bus.req_width;
                    // Zero gap is stretched to one cycle so pulses stay edge-separable.
                    gap_d   = (bus.req_gap == '0) ? PH_ONE : bus.req_gap;
                    if ((bus.req_width == '0) || (bus.req_count == '0)) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = HIGH;
                        phase_d = bus.req_width;
                        cnt_d   = bus.req_count;
                        pulse_d = 1'b1;
                    end
                end
            end
            HIGH: begin
                if (phase_q == PH_ONE) begin
                    if (cnt_q == CNT_ONE) begin
                        state_d = IDLE;
                        phase_d = '0;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = GAP;
                        phase_d = gap_q;
                        cnt_d   = cnt_q - CNT_ONE;
                    end
                end else begin
                    phase_d = phase_q - PH_ONE;
                    pulse_d = 1'b1;
                end
            end
            GAP: begin
                if (phase_q == PH_ONE) begin
                    state_d = HIGH;
                    phase_d = width_q;
                    pulse_d = 1'b1;
                end else begin
                    phase_d = phase_q - PH_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
                cnt_d   = '0;
            end
        endcase

        // Abort overrides everything in a running train and suppresses done.
        if (bus.abort && (state_q != IDLE)) begin
            state_d = IDLE;
            phase_d = '0;
            cnt_d   = '0;
            pulse_d = 1'b0;
            done_d  = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            phase_q <= '0;
            cnt_q   <= '0;
            width_q <= '0;
            gap_q   <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            width_q <= width_d;
            gap_q   <= gap_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.pulse = pulse_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed self-checking bench for pulse_train_gen.
module tb_pulse_train_gen;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    pulse_train_gen_if #(.W_WIDTH(4), .C_WIDTH(4)) bus ();

    pulse_train_gen #(.W_WIDTH(4), .C_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Waits for req_ready (bounded), presents the request and returns just
    // after the accept edge T. valid stays high when keep is set.
    task automatic send(input logic [3:0] w, input logic [3:0] g,
                        input logic [3:0] c, input bit keep);
        int k;
        @(negedge clk);
        bus.req_width = w;
        bus.req_gap   = g;
        bus.req_count = c;
        bus.req_valid = 1'b1;
        k = 0;
        while (bus.req_ready !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_ready_timeout: req_ready=%b required 1", bus.req_ready);
        end
        @(posedge clk);
        #1;
        if (!keep) bus.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        n_cmp++; if (bus.pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse: got %b want 0", bus.pulse); end
        n_cmp++; if (bus.busy  !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.done  !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.req_ready); end
    endtask

    task automatic test_basic();
        logic [8:0] exp_p, exp_b, exp_d;
        exp_p = 9'b110110110;   // MSB = cycle T+1
        exp_b = 9'b111111110;
        exp_d = 9'b000000001;
        send(4'd2, 4'd1, 4'd3, 1'b0);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            n_cmp++; if (bus.pulse !== exp_p[8-i]) begin n_fail++; $display("FAIL basic_pulse[T+%0d]: got %b want %b", i+1, bus.pulse, exp_p[8-i]); end
            n_cmp++; if (bus.busy  !== exp_b[8-i]) begin n_fail++; $display("FAIL basic_busy[T+%0d]: got %b want %b", i+1, bus.busy, exp_b[8-i]); end
            n_cmp++; if (bus.done  !== exp_d[8-i]) begin n_fail++; $display("FAIL basic_done[T+%0d]: got %b want %b", i+1, bus.done, exp_d[8-i]); end
        end
        @(negedge clk);
        n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL basic_done_once: got %b want 0", bus.done); end
    endtask

    task automatic test_gap_zero();
        logic [3:0] exp_p, exp_d;
        exp_p = 4'b1010;
        exp_d = 4'b0001;
        send(4'd1, 4'd0, 4'd2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++; if (bus.pulse !== exp_p[3-i]) begin n_fail++; $display("FAIL gap0_pulse[T+%0d]: got %b want %b", i+1, bus.pulse, exp_p[3-i]); end
            n_cmp++; if (bus.done  !== exp_d[3-i]) begin n_fail++; $display("FAIL gap0_done[T+%0d]: got %b want %b", i+1, bus.done, exp_d[3-i]); end
        end
    endtask

    task automatic test_zero_cfg();
        logic [3:0] ws [2];
        logic [3:0] cs [2];
        ws[0] = 4'd3; cs[0] = 4'd0;
        ws[1] = 4'd0; cs[1] = 4'd2;
        for (int j = 0; j < 2; j++) begin
            send(ws[j], 4'd1, cs[j], 1'b0);
            @(negedge clk);
            n_cmp++; if (bus.done  !== 1'b1) begin n_fail++; $display("FAIL zero%0d_done: got %b want 1", j, bus.done); end
            n_cmp++; if (bus.pulse !== 1'b0) begin n_fail++; $display("FAIL zero%0d_pulse: got %b want 0", j, bus.pulse); end
            n_cmp++; if (bus.busy  !== 1'b0) begin n_fail++; $display("FAIL zero%0d_busy: got %b want 0", j, bus.busy); end
            @(negedge clk);
            n_cmp++; if (bus.done  !== 1'b0) begin n_fail++; $display("FAIL zero%0d_done_once: got %b want 0", j, bus.done); end
            n_cmp++; if (bus.pulse !== 1'b0) begin n_fail++; $display("FAIL zero%0d_pulse2: got %b want 0", j, bus.pulse); end
        end
    endtask

    task automatic test_abort();
        send(4'd2, 4'd1, 4'd3, 1'b0);
        for (int i = 0; i < 6; i++) @(negedge clk);   // now in cycle T+6, second gap
        n_cmp++; if (bus.pulse !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL abort_pre: pulse=%b busy=%b want 0/1", bus.pulse, bus.busy); end
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.pulse     !== 1'b0) begin n_fail++; $display("FAIL abort_pulse: got %b want 0", bus.pulse); end
        n_cmp++; if (bus.busy      !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b want 1", bus.req_ready); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (bus.done !== 1'b0 || bus.pulse !== 1'b0) begin n_fail++; $display("FAIL abort_quiet[%0d]: done=%b pulse=%b want 0/0", i, bus.done, bus.pulse); end
            @(negedge clk);
        end
        // abort in IDLE only blocks the accept of that cycle
        bus.req_width = 4'd2; bus.req_gap = 4'd1; bus.req_count = 4'd1;
        bus.req_valid = 1'b1;
        bus.abort     = 1'b1;
        #1;
        n_cmp++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL abort_idle_ready: got %b want 0", bus.req_ready); end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.abort     = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b0 || bus.pulse !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL abort_idle_block: busy=%b pulse=%b done=%b want 0/0/0", bus.busy, bus.pulse, bus.done); end
    endtask

    task automatic test_back_to_back();
        logic [12:0] exp_p, exp_d, exp_r;
        exp_p = 13'b1101101101010;  // MSB = cycle T+1
        exp_d = 13'b0000000010001;
        exp_r = 13'b0000000010001;
        send(4'd2, 4'd1, 4'd3, 1'b1);
        bus.req_width = 4'd1; bus.req_gap = 4'd1; bus.req_count = 4'd2;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            n_cmp++; if (bus.pulse !== exp_p[12-i]) begin n_fail++; $display("FAIL b2b_pulse[T+%0d]: got %b want %b", i+1, bus.pulse, exp_p[12-i]); end
            n_cmp++; if (bus.done  !== exp_d[12-i]) begin n_fail++; $display("FAIL b2b_done[T+%0d]: got %b want %b", i+1, bus.done, exp_d[12-i]); end
            n_cmp++; if (bus.req_ready !== exp_r[12-i]) begin n_fail++; $display("FAIL b2b_ready[T+%0d]: got %b want %b", i+1, bus.req_ready, exp_r[12-i]); end
            if (i == 8) begin
                @(posedge clk);
                #1;
                bus.req_valid = 1'b0;
            end
        end
        @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b0 || bus.pulse !== 1'b0) begin n_fail++; $display("FAIL b2b_end: busy=%b pulse=%b want 0/0", bus.busy, bus.pulse); end
    endtask

    task automatic test_rst_mid();
        send(4'd3, 4'd1, 4'd2, 1'b0);
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (bus.pulse !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: pulse=%b want 1", bus.pulse); end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.pulse !== 1'b0) begin n_fail++; $display("FAIL rstmid_pulse: got %b want 0", bus.pulse); end
        n_cmp++; if (bus.busy  !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.done  !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b want 0", bus.done); end
        @(negedge clk);
        rst = 1'b1;
        send(4'd1, 4'd1, 4'd1, 1'b0);
        @(negedge clk);
        n_cmp++; if (bus.pulse !== 1'b1 || bus.done !== 1'b0) begin n_fail++; $display("FAIL rstmid_fresh1: pulse=%b done=%b want 1/0", bus.pulse, bus.done); end
        @(negedge clk);
        n_cmp++; if (bus.pulse !== 1'b0 || bus.done !== 1'b1) begin n_fail++; $display("FAIL rstmid_fresh2: pulse=%b done=%b want 0/1", bus.pulse, bus.done); end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        bus.req_valid = 1'b0;
        bus.req_width = '0;
        bus.req_gap   = '0;
        bus.req_count = '0;
        bus.abort     = 1'b0;
        test_reset();
        test_basic();
        test_gap_zero();
        test_zero_cfg();
        test_abort();
        test_back_to_back();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
